// File: rtl/winograd_ewmm_unit_if.sv
// Handshake and tile bus between a Winograd transform driver and the
// element-wise multiply stage.
interface winograd_ewmm_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TILE       = 6
);
    logic                  start;
    logic                  accumulate;
    logic [DATA_WIDTH-1:0] u_in  [0:TILE-1][0:TILE-1];
    logic [DATA_WIDTH-1:0] v_in  [0:TILE-1][0:TILE-1];
    logic [DATA_WIDTH-1:0] m_out [0:TILE-1][0:TILE-1];
    logic                  busy;
    logic                  done;

    modport master (
        output start, accumulate, u_in, v_in,
        input  m_out, busy, done
    );

    modport slave (
        input  start, accumulate, u_in, v_in,
        output m_out, busy, done
    );
endinterface

// File: rtl/winograd_ewmm_unit.sv
// Winograd F(4x4,3x3) Hadamard stage: M = U .* V (or M += U .* V), one row of
// TILE multipliers swept over TILE rows, one row per clock.
module winograd_ewmm_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TILE       = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    winograd_ewmm_unit_if.slave bus
);
    localparam int CW = (TILE > 1) ? $clog2(TILE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CW-1:0]         row_cnt;
    logic                  acc_cap;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] u_cap [0:TILE-1][0:TILE-1];
    logic [DATA_WIDTH-1:0] v_cap [0:TILE-1][0:TILE-1];
    logic [DATA_WIDTH-1:0] m_q   [0:TILE-1][0:TILE-1];

    logic [DATA_WIDTH-1:0] row_u   [0:TILE-1];
    logic [DATA_WIDTH-1:0] row_v   [0:TILE-1];
    logic [DATA_WIDTH-1:0] row_m   [0:TILE-1];
    logic [DATA_WIDTH-1:0] row_res [0:TILE-1];

    // Row mux feeding the shared multiplier row; products truncate to DATA_WIDTH.
    always_comb begin
        for (int unsigned c = 0; c < TILE; c++) begin
            row_u[c]   = '0;
            row_v[c]   = '0;
            row_m[c]   = '0;
            row_res[c] = '0;
        end
        for (int unsigned r = 0; r < TILE; r++) begin
            if (row_cnt == CW'(r)) begin
                for (int unsigned c = 0; c < TILE; c++) begin
                    row_u[c] = u_cap[r][c];
                    row_v[c] = v_cap[r][c];
                    row_m[c] = m_q[r][c];
                end
            end
        end
        for (int unsigned c = 0; c < TILE; c++) begin
            row_res[c] = acc_cap ? (row_m[c] + row_u[c] * row_v[c])
                                 : (row_u[c] * row_v[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            row_cnt <= '0;
            acc_cap <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned r = 0; r < TILE; r++) begin
                for (int unsigned c = 0; c < TILE; c++) begin
                    u_cap[r][c] <= '0;
                    v_cap[r][c] <= '0;
                    m_q[r][c]   <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        u_cap   <= bus.u_in;
                        v_cap   <= bus.v_in;
                        acc_cap <= bus.accumulate;
                        row_cnt <= '0;
                        busy_q  <= 1'b1;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    for (int unsigned r = 0; r < TILE; r++) begin
                        if (row_cnt == CW'(r)) begin
                            for (int unsigned c = 0; c < TILE; c++) begin
                                m_q[r][c] <= row_res[c];
                            end
                        end
                    end
                    row_cnt <= row_cnt + 1'b1;
                    if (row_cnt == CW'(TILE - 1)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_out = m_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
